// File: rtl/drc_burst_scheduler.sv
// Round-robin scheduler: pops one descriptor from a fair-chosen path and issues
// it to the AXI write pusher as 4 KiB-bounded fragments over valid/ready.
module drc_burst_scheduler #(
  parameter int p_paths = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [p_paths-1:0]    i_path_en,
  input  logic [p_paths-1:0]    paths_burst_empty,
  input  logic [p_paths*40-1:0] paths_burst_in,
  output logic [p_paths-1:0]    paths_burst_rd,
  output logic                  sched_valid,
  input  logic                  sched_ready,
  output logic [31:0]           sched_addr,
  output logic [8:0]            sched_len,
  output logic [p_paths-1:0]    sched_path,
  output logic                  sched_last,
  output logic                  o_busy,
  output logic                  o_err_zero_len
);

  localparam int IdxW = (p_paths > 1) ? $clog2(p_paths) : 1;

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [31:0]         addr_q, addr_d;
  logic [8:0]          rem_q, rem_d;
  logic [8:0]          frag_q, frag_d;
  logic [p_paths-1:0]  path_q, path_d;
  logic                last_q, last_d;
  logic                err_q, err_d;

  logic [p_paths-1:0]  req;
  logic                gntFound;
  logic [IdxW-1:0]     gntIdx;
  logic [39:0]         gntDesc;
  logic [p_paths-1:0]  rdRaw;
  int                  arbIdx;

  // Beats left before the next 4 KiB page, capped by what remains of the descriptor.
  function automatic logic [8:0] calcFrag(input logic [7:0] blk, input logic [8:0] rem);
    logic [8:0] toPage;
    toPage = 9'd256 - {1'b0, blk};
    return (rem < toPage) ? rem : toPage;
  endfunction

  assign req = ~paths_burst_empty & i_path_en;

  // Search upward from the path after the last grant so every path gets a turn.
  always_comb begin
    gntFound = 1'b0;
    gntIdx   = '0;
    gntDesc  = '0;
    arbIdx   = 0;
    for (int k = 1; k <= p_paths; k++) begin
      arbIdx = (int'(rr_ptr_q) + k) % p_paths;
      if (!gntFound && req[arbIdx]) begin
        gntFound = 1'b1;
        gntIdx   = IdxW'(arbIdx);
        gntDesc  = paths_burst_in[arbIdx*40 +: 40];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    frag_d   = frag_q;
    path_d   = path_q;
    last_d   = last_q;
    err_d    = 1'b0;
    rdRaw    = '0;
    case (state_q)
      IDLE: begin
        if (gntFound) begin
          rdRaw[gntIdx] = 1'b1;
          rr_ptr_d      = gntIdx;
          if (gntDesc[7:0] == 8'd0) begin
            err_d = 1'b1;
          end else begin
            addr_d         = gntDesc[39:8] & 32'hFFFF_FFF0;
            rem_d          = {1'b0, gntDesc[7:0]};
            frag_d         = calcFrag(addr_d[11:4], rem_d);
            last_d         = (frag_d == rem_d);
            path_d         = '0;
            path_d[gntIdx] = 1'b1;
            state_d        = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (sched_ready) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            addr_d = addr_q + {19'd0, frag_q, 4'd0};
            rem_d  = rem_q - frag_q;
            frag_d = calcFrag(addr_d[11:4], rem_d);
            last_d = (frag_d == rem_d);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      rem_q    <= '0;
      frag_q   <= '0;
      path_q   <= '0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      frag_q   <= frag_d;
      path_q   <= path_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  assign paths_burst_rd = i_rst ? '0 : rdRaw;
  assign sched_valid    = (state_q == ISSUE);
  assign o_busy         = (state_q != IDLE);
  assign sched_addr     = addr_q;
  assign sched_len      = frag_q;
  assign sched_path     = path_q;
  assign sched_last     = last_q;
  assign o_err_zero_len = err_q;

endmodule

// File: tb/tb_drc_burst_scheduler.sv
// Bench for drc_burst_scheduler: queue-based FIFO/fragment model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_drc_burst_scheduler;

  localparam int NP = 4;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [NP-1:0]     i_path_en;
  logic [NP-1:0]     paths_burst_empty;
  logic [NP*40-1:0]  paths_burst_in;
  logic [NP-1:0]     paths_burst_rd;
  logic              sched_valid;
  logic              sched_ready;
  logic [31:0]       sched_addr;
  logic [8:0]        sched_len;
  logic [NP-1:0]     sched_path;
  logic              sched_last;
  logic              o_busy;
  logic              o_err_zero_len;

  drc_burst_scheduler #(.p_paths(NP)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_path_en        (i_path_en),
    .paths_burst_empty(paths_burst_empty),
    .paths_burst_in   (paths_burst_in),
    .paths_burst_rd   (paths_burst_rd),
    .sched_valid      (sched_valid),
    .sched_ready      (sched_ready),
    .sched_addr       (sched_addr),
    .sched_len        (sched_len),
    .sched_path       (sched_path),
    .sched_last       (sched_last),
    .o_busy           (o_busy),
    .o_err_zero_len   (o_err_zero_len)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0]   addr;
    logic [8:0]    len;
    logic [NP-1:0] path;
    logic          last;
  } frag_t;

  typedef struct packed {
    logic [1:0]  p;
    logic [39:0] d;
  } push_t;

  int          nChecks = 0;
  int          nFails  = 0;
  logic [39:0] fifoQ[NP][$];
  push_t       pendQ[$];
  frag_t       expFrags[$];
  int          rrPtr = 0;
  logic        expErr = 1'b0;
  int          grantLog[$];
  int          maskedPulses = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Present the head of each modelled FIFO to the DUT (first-word fall-through).
  task automatic driveFifos();
    for (int i = 0; i < NP; i++) begin
      paths_burst_empty[i] = (fifoQ[i].size() == 0);
      paths_burst_in[i*40 +: 40] = (fifoQ[i].size() == 0) ? 40'd0 : fifoQ[i][0];
    end
  endtask

  // Walk the descriptor page by page, recording every fragment the pusher must see.
  task automatic buildFrags(input int p, input logic [39:0] d);
    logic [31:0] a;
    int rem, room, f;
    frag_t fr;
    a   = d[39:8] & 32'hFFFF_FFF0;
    rem = int'(d[7:0]);
    while (rem > 0) begin
      room    = (4096 - int'(a % 32'd4096)) / 16;
      f       = (rem < room) ? rem : room;
      fr.addr = a;
      fr.len  = 9'(f);
      fr.path = NP'(1 << p);
      fr.last = (f == rem);
      expFrags.push_back(fr);
      a   = a + 32'(f * 16);
      rem = rem - f;
    end
  endtask

  // Reference model: owns the FIFOs, predicts grants and fragments, compares every cycle.
  initial begin : model
    int popPath;
    logic take;
    logic [NP-1:0] expRd;
    logic expValid;
    logic [39:0] d;
    driveFifos();
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        expFrags.delete();
        rrPtr  = 0;
        expErr = 1'b0;
        checkOutput("rst_valid", 64'(sched_valid), 64'd0);
        checkOutput("rst_rd", 64'(paths_burst_rd), 64'd0);
        checkOutput("rst_busy", 64'(o_busy), 64'd0);
        checkOutput("rst_err", 64'(o_err_zero_len), 64'd0);
        checkOutput("rst_addr", 64'(sched_addr), 64'd0);
        checkOutput("rst_len", 64'(sched_len), 64'd0);
        checkOutput("rst_path", 64'(sched_path), 64'd0);
        checkOutput("rst_last", 64'(sched_last), 64'd0);
        continue;
      end
      expValid = (expFrags.size() > 0);
      popPath  = -1;
      take     = 1'b0;
      expRd    = '0;
      checkOutput("valid", 64'(sched_valid), 64'(expValid));
      checkOutput("busy", 64'(o_busy), 64'(expValid));
      checkOutput("err_zero_len", 64'(o_err_zero_len), 64'(expErr));
      if (expValid) begin
        checkOutput("addr", 64'(sched_addr), 64'(expFrags[0].addr));
        checkOutput("len", 64'(sched_len), 64'(expFrags[0].len));
        checkOutput("path", 64'(sched_path), 64'(expFrags[0].path));
        checkOutput("last", 64'(sched_last), 64'(expFrags[0].last));
        take = sched_ready;
      end else begin
        for (int k = 1; k <= NP; k++) begin
          int i;
          i = (rrPtr + k) % NP;
          if (popPath < 0 && fifoQ[i].size() > 0 && i_path_en[i]) popPath = i;
        end
        if (popPath >= 0) expRd[popPath] = 1'b1;
      end
      checkOutput("rd", 64'(paths_burst_rd), 64'(expRd));
      @(posedge i_clk);
      #1;
      expErr = 1'b0;
      if (take) void'(expFrags.pop_front());
      if (popPath >= 0) begin
        d     = fifoQ[popPath].pop_front();
        rrPtr = popPath;
        if (d[7:0] == 8'd0) expErr = 1'b1;
        else buildFrags(popPath, d);
      end
      while (pendQ.size() > 0) begin
        push_t pp;
        pp = pendQ.pop_front();
        fifoQ[int'(pp.p)].push_back(pp.d);
      end
      driveFifos();
    end
  end

  // Observed grant order and pops of masked paths.
  initial begin : monitor
    forever begin
      @(negedge i_clk);
      if (!i_rst && paths_burst_rd != '0) begin
        int idx;
        idx = 99;
        for (int i = 0; i < NP; i++) if (paths_burst_rd == NP'(1 << i)) idx = i;
        grantLog.push_back(idx);
        if (paths_burst_rd[1] || paths_burst_rd[3]) maskedPulses++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepCycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input int p, input logic [31:0] addr, input logic [7:0] len);
    push_t pp;
    pp.p = 2'(p);
    pp.d = {addr, len};
    pendQ.push_back(pp);
  endtask

  task automatic waitValid(input string name, output logic [NP-1:0] rdBefore);
    logic [NP-1:0] prev;
    prev     = '0;
    rdBefore = '0;
    for (int n = 0; n < 50; n++) begin
      @(negedge i_clk);
      if (sched_valid) begin
        rdBefore = prev;
        return;
      end
      prev = paths_burst_rd;
    end
    checkOutput({name, "_valid_timeout"}, 64'd0, 64'd1);
  endtask

  function automatic logic isDrained(input logic [NP-1:0] mask);
    logic ok;
    ok = (pendQ.size() == 0) && (expFrags.size() == 0) && !sched_valid;
    for (int i = 0; i < NP; i++) if (mask[i] && fifoQ[i].size() != 0) ok = 1'b0;
    return ok;
  endfunction

  task automatic waitDrain(input string name, input logic [NP-1:0] mask);
    for (int n = 0; n < 400; n++) begin
      @(negedge i_clk);
      if (isDrained(mask)) return;
    end
    checkOutput({name, "_drain_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin : stimulus
    logic [NP-1:0] rdBefore;
    int validCnt, rdCnt;
    logic sawRd1, sawErr, sawValid;
    int expOrder[12];
    expOrder = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
    i_path_en   = '1;
    sched_ready = 1'b0;
    i_rst       = 1'b1;
    repeat (3) stepCycle();
    i_rst = 1'b0;

    // Single descriptor, one fragment
    sched_ready = 1'b1;
    applyStimulus(0, 32'h0000_1000, 8'd4);
    waitValid("t1", rdBefore);
    checkOutput("t1_rd_before_valid", 64'(rdBefore), 64'h1);
    checkOutput("t1_addr", 64'(sched_addr), 64'h1000);
    checkOutput("t1_len", 64'(sched_len), 64'd4);
    checkOutput("t1_last", 64'(sched_last), 64'd1);
    checkOutput("t1_path", 64'(sched_path), 64'h1);
    @(negedge i_clk);
    checkOutput("t1_valid_drop", 64'(sched_valid), 64'd0);
    waitDrain("t1", '1);

    // 4 KiB split
    stepCycle();
    applyStimulus(0, 32'h0000_0FC0, 8'd10);
    waitValid("t2", rdBefore);
    checkOutput("t2a_addr", 64'(sched_addr), 64'h0FC0);
    checkOutput("t2a_len", 64'(sched_len), 64'd4);
    checkOutput("t2a_last", 64'(sched_last), 64'd0);
    @(negedge i_clk);
    checkOutput("t2b_valid", 64'(sched_valid), 64'd1);
    checkOutput("t2b_addr", 64'(sched_addr), 64'h1000);
    checkOutput("t2b_len", 64'(sched_len), 64'd6);
    checkOutput("t2b_last", 64'(sched_last), 64'd1);
    waitDrain("t2", '1);

    // Address wrap past the top of the space, low nibble discarded
    stepCycle();
    applyStimulus(0, 32'hFFFF_FFC8, 8'd8);
    waitValid("t2w", rdBefore);
    checkOutput("t2w_a_addr", 64'(sched_addr), 64'hFFFF_FFC0);
    checkOutput("t2w_a_len", 64'(sched_len), 64'd4);
    @(negedge i_clk);
    checkOutput("t2w_b_addr", 64'(sched_addr), 64'h0);
    checkOutput("t2w_b_len", 64'(sched_len), 64'd4);
    checkOutput("t2w_b_last", 64'(sched_last), 64'd1);
    waitDrain("t2w", '1);

    // Maximum length crossing one page by a single beat
    stepCycle();
    applyStimulus(0, 32'h0000_0020, 8'd255);
    waitValid("t2m", rdBefore);
    checkOutput("t2m_a_len", 64'(sched_len), 64'd254);
    checkOutput("t2m_a_last", 64'(sched_last), 64'd0);
    @(negedge i_clk);
    checkOutput("t2m_b_addr", 64'(sched_addr), 64'h1000);
    checkOutput("t2m_b_len", 64'(sched_len), 64'd1);
    waitDrain("t2m", '1);

    // Fairness across four loaded paths
    stepCycle();
    grantLog.delete();
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < NP; p++)
        applyStimulus(p, 32'h0000_8000 + 32'(p * 256) + 32'(k * 64), 8'd2);
    waitDrain("t3", '1);
    checkOutput("t3_grant_count", 64'(grantLog.size()), 64'd12);
    for (int i = 0; i < 12; i++)
      checkOutput($sformatf("t3_grant%0d", i), 64'((i < grantLog.size()) ? grantLog[i] : -1), 64'(expOrder[i]));

    // Backpressure
    stepCycle();
    sched_ready = 1'b0;
    applyStimulus(2, 32'h0000_2000, 8'd8);
    waitValid("t4", rdBefore);
    validCnt = 0;
    rdCnt    = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      if (sched_valid) validCnt++;
      if (paths_burst_rd != '0) rdCnt++;
    end
    checkOutput("t4_valid_held", 64'(validCnt), 64'd5);
    checkOutput("t4_no_extra_rd", 64'(rdCnt), 64'd0);
    checkOutput("t4_addr_stable", 64'(sched_addr), 64'h2000);
    stepCycle();
    sched_ready = 1'b1;
    waitDrain("t4", '1);

    // Zero-length descriptor
    stepCycle();
    applyStimulus(1, 32'h0000_3000, 8'd0);
    sawRd1   = 1'b0;
    sawErr   = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 10 && !sawErr; i++) begin
      @(negedge i_clk);
      if (paths_burst_rd == 4'b0010) sawRd1 = 1'b1;
      if (o_err_zero_len) sawErr = 1'b1;
      if (sched_valid) sawValid = 1'b1;
    end
    checkOutput("t5_rd1", 64'(sawRd1), 64'd1);
    checkOutput("t5_err_pulse", 64'(sawErr), 64'd1);
    checkOutput("t5_no_valid", 64'(sawValid), 64'd0);
    stepCycle();
    applyStimulus(3, 32'h0000_3040, 8'd2);
    waitValid("t5", rdBefore);
    checkOutput("t5_next_path", 64'(sched_path), 64'b1000);
    waitDrain("t5", '1);

    // Enable mask
    stepCycle();
    i_path_en    = 4'b0101;
    maskedPulses = 0;
    for (int p = 0; p < NP; p++) applyStimulus(p, 32'h0000_5000 + 32'(p * 256), 8'd3);
    waitDrain("t6m", 4'b0101);
    repeat (4) @(negedge i_clk);
    checkOutput("t6_masked_pops", 64'(maskedPulses), 64'd0);

    // Reset in the middle of an issue
    stepCycle();
    sched_ready = 1'b0;
    i_path_en   = 4'b1111;
    waitValid("t6r", rdBefore);
    checkOutput("t6r_path", 64'(sched_path), 64'b1000);
    #2;
    i_rst = 1'b1;
    #1;
    checkOutput("t6r_valid_drop", 64'(sched_valid), 64'd0);
    checkOutput("t6r_busy_drop", 64'(o_busy), 64'd0);
    stepCycle();
    stepCycle();
    i_rst       = 1'b0;
    sched_ready = 1'b1;
    waitValid("t6a", rdBefore);
    checkOutput("t6a_path", 64'(sched_path), 64'b0010);
    checkOutput("t6a_addr", 64'(sched_addr), 64'h5100);
    waitDrain("t6a", '1);

    repeat (2) @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
